// File: rtl/sp_access_ctrl_if.sv
// rtl/sp_access_ctrl_if.sv - engine write, host burst read and SP port signal bundle
interface sp_access_ctrl_if #(
    parameter int BUS_WIDTH = 64,
    parameter int AW        = 2,
    parameter int TW        = 2
);
    logic                 eng_wr_req_i;
    logic [TW-1:0]        eng_wr_target_i;
    logic [AW-1:0]        eng_wr_addr_i;
    logic [BUS_WIDTH-1:0] eng_wr_data_i;
    logic                 eng_wr_gnt_o;
    logic                 host_rd_req_i;
    logic [TW-1:0]        host_rd_target_i;
    logic                 host_rd_busy_o;
    logic [BUS_WIDTH-1:0] rd_data_o;
    logic                 rd_valid_o;
    logic                 rd_last_o;
    logic                 rd_ready_i;
    logic                 rd_done_o;
    logic                 sp_we_o;
    logic [TW-1:0]        sp_wtarget_o;
    logic [AW-1:0]        sp_waddr_o;
    logic [BUS_WIDTH-1:0] sp_wdata_o;
    logic [TW-1:0]        sp_rtarget_o;
    logic [AW-1:0]        sp_raddr_o;
    logic [BUS_WIDTH-1:0] sp_rdata_i;

    modport slave (
        input  eng_wr_req_i, eng_wr_target_i, eng_wr_addr_i, eng_wr_data_i,
        input  host_rd_req_i, host_rd_target_i, rd_ready_i, sp_rdata_i,
        output eng_wr_gnt_o, host_rd_busy_o, rd_data_o, rd_valid_o, rd_last_o, rd_done_o,
        output sp_we_o, sp_wtarget_o, sp_waddr_o, sp_wdata_o, sp_rtarget_o, sp_raddr_o
    );

    modport master (
        output eng_wr_req_i, eng_wr_target_i, eng_wr_addr_i, eng_wr_data_i,
        output host_rd_req_i, host_rd_target_i, rd_ready_i, sp_rdata_i,
        input  eng_wr_gnt_o, host_rd_busy_o, rd_data_o, rd_valid_o, rd_last_o, rd_done_o,
        input  sp_we_o, sp_wtarget_o, sp_waddr_o, sp_wdata_o, sp_rtarget_o, sp_raddr_o
    );
endinterface

// File: rtl/sp_access_ctrl.sv
// rtl/sp_access_ctrl.sv - scratchpad arbiter: engine row writes vs host burst reads
// Optional feature macro: SP_CLEAR_ON_READ_EN (zero each row as the burst captures it)
module sp_access_ctrl #(
    parameter int SP_NTARGETS = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int BUS_WIDTH   = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    sp_access_ctrl_if.slave    bus
);
    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
    localparam int AW      = 2 * $clog2(MAX_DIM);
    localparam int ROWS    = MAX_DIM * MAX_DIM;
    localparam int TW      = $clog2(SP_NTARGETS);
    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]           state;
    logic                 last_eng;
    logic [TW-1:0]        burst_target;
    logic [AW-1:0]        rcnt;
    logic                 rows_left;
    logic [BUS_WIDTH-1:0] rd_data;
    logic                 rd_valid;
    logic                 rd_last;
    logic                 rd_done;

    logic in_idle, in_burst, host_win, load, accept_last, eng_gnt;

    assign in_idle  = (state == ST_IDLE);
    assign in_burst = (state == ST_BURST);

    // last_eng=0 after reset means the host counts as the previous winner
    assign host_win    = in_idle & bus.host_rd_req_i & (~bus.eng_wr_req_i | last_eng);
    assign load        = in_burst & rows_left & (~rd_valid | bus.rd_ready_i);
    assign accept_last = rd_valid & bus.rd_ready_i & rd_last;

`ifdef SP_CLEAR_ON_READ_EN
    assign eng_gnt = bus.eng_wr_req_i & ~in_burst & ~host_win;
`else
    assign eng_gnt = bus.eng_wr_req_i & ~(in_burst & (bus.eng_wr_target_i == burst_target))
                     & ~host_win;
`endif

    always_comb begin
        bus.sp_we_o      = 1'b0;
        bus.sp_wtarget_o = '0;
        bus.sp_waddr_o   = '0;
        bus.sp_wdata_o   = '0;
        if (eng_gnt) begin
            bus.sp_we_o      = 1'b1;
            bus.sp_wtarget_o = bus.eng_wr_target_i;
            bus.sp_waddr_o   = bus.eng_wr_addr_i;
            bus.sp_wdata_o   = bus.eng_wr_data_i;
        end
`ifdef SP_CLEAR_ON_READ_EN
        if (load) begin
            bus.sp_we_o      = 1'b1;
            bus.sp_wtarget_o = burst_target;
            bus.sp_waddr_o   = rcnt;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= ST_IDLE;
            last_eng     <= 1'b0;
            burst_target <= '0;
            rcnt         <= '0;
            rows_left    <= 1'b0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
            rd_last      <= 1'b0;
            rd_done      <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            if (in_idle) begin
                if (host_win) begin
                    state        <= ST_BURST;
                    burst_target <= bus.host_rd_target_i;
                    rcnt         <= '0;
                    rows_left    <= 1'b1;
                    last_eng     <= 1'b0;
                end else if (bus.eng_wr_req_i) begin
                    last_eng <= 1'b1;
                end
            end
            if (load) begin
                rd_data  <= bus.sp_rdata_i;
                rd_valid <= 1'b1;
                rd_last  <= (rcnt == LAST_ROW);
                // counter parks on the final row instead of wrapping
                if (rcnt == LAST_ROW) rows_left <= 1'b0;
                else                  rcnt      <= rcnt + 1'b1;
            end else if (rd_valid & bus.rd_ready_i) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end
            if (accept_last) begin
                rd_done <= 1'b1;
                state   <= ST_IDLE;
            end
        end
    end

    assign bus.eng_wr_gnt_o   = eng_gnt;
    assign bus.host_rd_busy_o = in_burst;
    assign bus.rd_data_o      = rd_data;
    assign bus.rd_valid_o     = rd_valid;
    assign bus.rd_last_o      = rd_last;
    assign bus.rd_done_o      = rd_done;
    assign bus.sp_rtarget_o   = burst_target;
    assign bus.sp_raddr_o     = rcnt;
endmodule

// File: tb/tb_sp_access_ctrl.sv
// tb/tb_sp_access_ctrl.sv - self-checking bench for sp_access_ctrl with a behavioural SP
module tb_sp_access_ctrl;
    localparam int BW = 64;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sp_access_ctrl_if #(.BUS_WIDTH(BW), .AW(AW), .TW(2)) bus ();

    sp_access_ctrl #(.SP_NTARGETS(4), .DATA_WIDTH(32), .BUS_WIDTH(BW)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    function automatic logic [63:0] pat(input int t, input int r);
        return {32'hC0DE_0000 + 32'(t), 32'h5A5A_0000 + 32'(r)};
    endfunction

    logic [63:0] mem [4][4];
    logic        mem_init = 1'b1;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int t = 0; t < 4; t++)
                for (int r = 0; r < 4; r++) mem[t][r] <= pat(t, r);
        end else if (bus.sp_we_o) begin
            mem[bus.sp_wtarget_o][bus.sp_waddr_o] <= bus.sp_wdata_o;
        end
    end
    assign bus.sp_rdata_i = mem[bus.sp_rtarget_o][bus.sp_raddr_o];

    logic [63:0] exp_mem [4][4];
    logic [63:0] exp_rows [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_burst(input logic [1:0] tgt, input logic [15:0] stall,
                             input bit timing, input bit do_start);
        int nb;
        bit done_seen;
        logic pv, pr, pl;
        logic [63:0] pd;
        for (int r = 0; r < 4; r++) exp_rows[r] = exp_mem[tgt][r];
        if (do_start) begin
            @(negedge clk);
            bus.host_rd_req_i = 1'b1;
            bus.host_rd_target_i = tgt;
            @(negedge clk);
            bus.host_rd_req_i = 1'b0;
            check("burst_busy", 64'(bus.host_rd_busy_o), 64'd1);
            check("entry_valid_low", 64'(bus.rd_valid_o), 64'd0);
        end
        nb = 0; done_seen = 0; pv = 0; pr = 1; pl = 0; pd = '0;
        for (int c = 0; c < 40 && !done_seen; c++) begin
            bus.rd_ready_i = (c < 16) ? ~stall[c] : 1'b1;
            #1;
            if (pv && !pr) begin
                check("hold_valid", 64'(bus.rd_valid_o), 64'd1);
                check("hold_data", bus.rd_data_o, pd);
                check("hold_last", 64'(bus.rd_last_o), 64'(pl));
            end
            if (bus.rd_done_o) begin
                done_seen = 1;
                check("beats_at_done", 64'(nb), 64'd4);
                check("busy_drop_at_done", 64'(bus.host_rd_busy_o), 64'd0);
                if (timing) check("done_cycle", 64'(c), 64'd5);
            end else if (bus.rd_valid_o && bus.rd_ready_i) begin
                if (nb >= 4) begin
                    check("extra_beat", 64'(nb), 64'd3);
                end else begin
                    check($sformatf("beat%0d_data", nb), bus.rd_data_o, exp_rows[nb]);
                    check($sformatf("beat%0d_last", nb), 64'(bus.rd_last_o), 64'(nb == 3));
                    if (timing) check($sformatf("beat%0d_cycle", nb), 64'(c), 64'(nb + 1));
                end
                nb++;
            end
            pv = bus.rd_valid_o; pr = bus.rd_ready_i; pl = bus.rd_last_o; pd = bus.rd_data_o;
            @(negedge clk);
        end
        check("burst_done_seen", 64'(done_seen), 64'd1);
        check("done_one_cycle", 64'(bus.rd_done_o), 64'd0);
        check("rcnt_no_wrap", 64'(bus.sp_raddr_o), 64'd3);
        bus.rd_ready_i = 1'b0;
`ifdef SP_CLEAR_ON_READ_EN
        for (int r = 0; r < 4; r++) exp_mem[tgt][r] = '0;
`endif
    endtask

    typedef struct {
        logic        req;
        logic [1:0]  tgt;
        logic [1:0]  addr;
        logic [63:0] data;
        logic        gnt;
    } vec_t;
    vec_t vecs [6];

    initial begin
        bit   seen;
        logic exp_g;
        vecs[0] = '{1'b1, 2'd1, 2'd2, 64'h0000_0000_0000_00A5, 1'b1};
        vecs[1] = '{1'b0, 2'd2, 2'd1, 64'h0000_0000_0000_FFFF, 1'b0};
        vecs[2] = '{1'b1, 2'd0, 2'd3, 64'hDEAD_BEEF_CAFE_F00D, 1'b1};
        vecs[3] = '{1'b1, 2'd1, 2'd0, 64'h0000_0000_0000_1111, 1'b1};
        vecs[4] = '{1'b1, 2'd3, 2'd1, 64'h0123_4567_89AB_CDEF, 1'b1};
        vecs[5] = '{1'b1, 2'd1, 2'd3, 64'h8000_0000_0000_0001, 1'b1};
        for (int t = 0; t < 4; t++)
            for (int r = 0; r < 4; r++) exp_mem[t][r] = pat(t, r);

        bus.eng_wr_req_i = 0; bus.eng_wr_target_i = 0; bus.eng_wr_addr_i = 0;
        bus.eng_wr_data_i = 0; bus.host_rd_req_i = 0; bus.host_rd_target_i = 0;
        bus.rd_ready_i = 0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", 64'(bus.rd_valid_o), 64'd0);
        check("rst_busy", 64'(bus.host_rd_busy_o), 64'd0);
        check("rst_data", bus.rd_data_o, 64'd0);
        check("rst_sp_we", 64'(bus.sp_we_o), 64'd0);
        rst_n = 1'b1;
        mem_init = 1'b0;
        @(negedge clk);
        check("idle_outputs", {bus.rd_valid_o, bus.rd_last_o, bus.rd_done_o, bus.host_rd_busy_o,
              bus.eng_wr_gnt_o, bus.sp_we_o, bus.sp_raddr_o, bus.sp_rtarget_o}, 64'd0);

        // table of engine writes in IDLE
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.eng_wr_req_i = vecs[i].req;
            bus.eng_wr_target_i = vecs[i].tgt;
            bus.eng_wr_addr_i = vecs[i].addr;
            bus.eng_wr_data_i = vecs[i].data;
            #1;
            check($sformatf("vec%0d_gnt", i), 64'(bus.eng_wr_gnt_o), 64'(vecs[i].gnt));
            check($sformatf("vec%0d_we", i), 64'(bus.sp_we_o), 64'(vecs[i].gnt));
            if (vecs[i].gnt) begin
                check($sformatf("vec%0d_wtgt", i), 64'(bus.sp_wtarget_o), 64'(vecs[i].tgt));
                check($sformatf("vec%0d_waddr", i), 64'(bus.sp_waddr_o), 64'(vecs[i].addr));
                check($sformatf("vec%0d_wdata", i), bus.sp_wdata_o, vecs[i].data);
                exp_mem[vecs[i].tgt][vecs[i].addr] = vecs[i].data;
            end
        end
        @(negedge clk);
        bus.eng_wr_req_i = 0;

        // full-throughput burst, exact cycle timing
        run_burst(2'd2, 16'h0000, 1, 1);
        // back-pressure on cycles 2-3, verifies the table writes landed
        run_burst(2'd1, 16'h000C, 0, 1);

        // round-robin after reset, target stall and other-target grant during burst
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.eng_wr_req_i = 1; bus.eng_wr_target_i = 2'd1; bus.eng_wr_addr_i = 2'd0;
        bus.eng_wr_data_i = 64'h4444;
        bus.host_rd_req_i = 1; bus.host_rd_target_i = 2'd2;
        #1;
        check("rr_first_eng_gnt", 64'(bus.eng_wr_gnt_o), 64'd1);
        exp_mem[1][0] = 64'h4444;
        @(negedge clk);
        check("rr_first_no_burst", 64'(bus.host_rd_busy_o), 64'd0);
        check("rr_second_eng_lose", 64'(bus.eng_wr_gnt_o), 64'd0);
        @(negedge clk);
        bus.host_rd_req_i = 0;
        check("rr_second_host_busy", 64'(bus.host_rd_busy_o), 64'd1);
        bus.eng_wr_target_i = 2'd2; bus.eng_wr_addr_i = 2'd3; bus.eng_wr_data_i = 64'h9999;
        #1;
        check("burst_tgt_stall", 64'(bus.eng_wr_gnt_o), 64'd0);
        bus.eng_wr_target_i = 2'd0; bus.eng_wr_addr_i = 2'd1; bus.eng_wr_data_i = 64'h7777;
        #1;
`ifdef SP_CLEAR_ON_READ_EN
        exp_g = 1'b0;
`else
        exp_g = 1'b1;
`endif
        check("other_tgt_gnt", 64'(bus.eng_wr_gnt_o), 64'(exp_g));
        if (exp_g) exp_mem[0][1] = 64'h7777;
        @(negedge clk);
        bus.eng_wr_req_i = 0;
        run_burst(2'd2, 16'h0000, 0, 0);
        bus.eng_wr_req_i = 1; bus.eng_wr_target_i = 2'd2; bus.eng_wr_addr_i = 2'd3;
        bus.eng_wr_data_i = 64'h3333;
        #1;
        check("stalled_tgt_gnt_idle", 64'(bus.eng_wr_gnt_o), 64'd1);
        exp_mem[2][3] = 64'h3333;
        @(negedge clk);
        bus.eng_wr_req_i = 0;
        run_burst(2'd0, 16'h0000, 0, 1);

        // asynchronous reset at beat 2
        @(negedge clk);
        bus.host_rd_req_i = 1; bus.host_rd_target_i = 2'd1;
        @(negedge clk);
        bus.host_rd_req_i = 0;
        bus.rd_ready_i = 1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_beat2", bus.rd_data_o, exp_mem[1][2]);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", 64'(bus.rd_valid_o), 64'd0);
        check("async_busy", 64'(bus.host_rd_busy_o), 64'd0);
        check("async_raddr", 64'(bus.sp_raddr_o), 64'd0);
`ifdef SP_CLEAR_ON_READ_EN
        for (int r = 0; r < 3; r++) exp_mem[1][r] = '0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        bus.rd_ready_i = 0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.rd_done_o) seen = 1;
        end
        check("no_done_after_abort", 64'(seen), 64'd0);
        run_burst(2'd1, 16'h0000, 1, 1);

        // re-read of the same target: zeros when clear-on-read is built in
        run_burst(2'd3, 16'h0000, 0, 1);
        run_burst(2'd3, 16'h0000, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
